// File: rtl/mul_pf_seq.sv
// -----------------------------------------------------------------------------
// mul_pf_seq
//
// Sequential signed Q4.4 x Q4.4 multiplier with a Q4.4 saturated result.
// The exact Q8.8 product is built in a 16-bit accumulator over eight
// shift-and-add iterations, one per clock. Bits 0..6 of the multiplier add a
// shifted copy of the multiplicand. Bit 7 carries negative weight in two's
// complement, so its step subtracts. The product is then floored back to Q4.4
// with an arithmetic shift and clamped to the 8-bit range.
//
// Handshake: a start seen in IDLE captures both operands. busy covers RUN and
// DONE, and done pulses for the single DONE cycle. result and overflow hold
// their values until the next DONE.
//
// Ports
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset
//   start         in   1  request, sampled only in IDLE
//   multiplicand  in   8  signed Q4.4 operand A, captured on accepted start
//   multiplier    in   8  signed Q4.4 operand B, captured on accepted start
//   busy          out  1  high in RUN and DONE
//   done          out  1  one-cycle pulse, result/overflow valid
//   result        out  8  signed Q4.4 product, saturated
//   overflow      out  1  high when result was saturated
// -----------------------------------------------------------------------------
module mul_pf_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] multiplicand,
   input  logic [7:0] multiplier,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic        [7:0]  a_reg;      // captured multiplicand
   logic        [7:0]  b_reg;      // captured multiplier, bit cnt selects the step
   logic signed [15:0] acc;        // running Q8.8 partial product
   logic        [2:0]  cnt;        // iteration index, wraps 7 -> 0

   logic signed [15:0] a_ext;      // multiplicand sign-extended to Q8.8 width
   logic signed [15:0] partial;    // a_ext weighted by 2^cnt
   logic signed [15:0] acc_nxt;    // accumulator after this iteration
   logic        [11:0] s_val;      // acc_nxt >>> 4, still full width
   logic               s_fits;     // s_val is representable in 8 bits
   logic        [7:0]  sat_res;
   logic               sat_ov;
   logic               last_iter;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: every clocked register in this file uses non-blocking assignments,
   // so all of them sample their inputs together on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: state_nxt gets a default before the case statement. Without it,
   // any path that left it unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt == 3'd7) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // One shift-and-add iteration
   // --------------------------------------------------------------------------
   assign a_ext   = {{8{a_reg[7]}}, a_reg};
   assign partial = a_ext <<< cnt;

   // Steps 0..6 add while step 7 subtracts. That makes B's MSB count as -128,
   // which is what keeps -128 x -128 = +16384 exact. Every intermediate value
   // stays within +/-16384, so the 16-bit accumulator never wraps.
   always_comb begin
      acc_nxt = acc;
      if (b_reg[cnt]) begin
         if (cnt == 3'd7) begin
            acc_nxt = acc - partial;
         end else begin
            acc_nxt = acc + partial;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Q8.8 -> Q4.4 with floor and saturation
   // --------------------------------------------------------------------------
   // Dropping the low four bits of a two's-complement value is an arithmetic
   // right shift, so negative products round toward minus infinity.
   assign s_val = acc_nxt[15:4];

   // The value fits in signed 8 bits only when bits 11..7 all match the sign.
   assign s_fits  = (s_val[11:7] == {5{s_val[11]}});
   assign sat_ov  = ~s_fits;
   assign sat_res = s_fits      ? s_val[7:0] :
                    s_val[11]   ? 8'h80      :
                                  8'h7F;

   assign last_iter = (state == S_RUN) && (cnt == 3'd7);

   // --------------------------------------------------------------------------
   // Datapath registers
   // --------------------------------------------------------------------------
   // Operands are sampled only on the accepting edge, so later changes on the
   // inputs and a start seen while busy have no effect on the operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= 8'h00;
         b_reg    <= 8'h00;
         acc      <= 16'sd0;
         cnt      <= 3'd0;
         result   <= 8'h00;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg <= multiplicand;
                  b_reg <= multiplier;
                  acc   <= 16'sd0;
                  cnt   <= 3'd0;
               end
            end
            S_RUN: begin
               acc <= acc_nxt;
               cnt <= cnt + 3'd1;
               // The final iteration's sum goes straight to the output
               // registers on the same edge that enters DONE.
               if (last_iter) begin
                  result   <= sat_res;
                  overflow <= sat_ov;
               end
            end
            default: begin
               // DONE: hold everything.
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Handshake outputs, decoded from the state register
   // --------------------------------------------------------------------------
   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_pf_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_pf_seq
//
// Self-checking bench for mul_pf_seq. Each accepted operation pushes its
// expected {result, overflow} into a scoreboard queue. A monitor on the
// falling edge pops and compares an entry on every done. Between done pulses
// it checks that the held outputs still match the last popped entry.
// -----------------------------------------------------------------------------
module tb_mul_pf_seq;

   typedef struct packed {
      logic [7:0] res;
      logic       ov;
   } exp_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       ov;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] mcand;
   logic [7:0] mplier;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       overflow;

   int   checks;
   int   failures;
   int   cyc;
   int   done_count;
   bit   spacing_on;
   bit   have_prev;
   int   prev_done_cyc;
   exp_t last_exp;
   exp_t sb_q[$];

   mul_pf_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (mcand),
      .multiplier   (mplier),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: floor(A*B/16) with clamping to the signed 8-bit range.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
      int   p;
      int   s;
      exp_t e;
      p = int'($signed(a)) * int'($signed(b));
      s = p >>> 4;
      if (s > 127) begin
         e.res = 8'h7F;
         e.ov  = 1'b1;
      end else if (s < -128) begin
         e.res = 8'h80;
         e.ov  = 1'b1;
      end else begin
         e.res = 8'(s);
         e.ov  = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_exp = '0;
      end else if (done) begin
         done_count++;
         if (spacing_on) begin
            if (have_prev) begin
               check("done_spacing", 16'(cyc - prev_done_cyc), 16'd10);
            end
            have_prev     = 1'b1;
            prev_done_cyc = cyc;
         end
         if (sb_q.size() == 0) begin
            check("unexpected_done", 16'd1, 16'd0);
         end else begin
            last_exp = sb_q.pop_front();
            check("result", {8'h00, result}, {8'h00, last_exp.res});
            check("overflow", {15'd0, overflow}, {15'd0, last_exp.ov});
         end
      end else begin
         if ({result, overflow} !== {last_exp.res, last_exp.ov}) begin
            check("hold", {7'd0, result, overflow}, {7'd0, last_exp.res, last_exp.ov});
         end
      end
   end

   // Waits (bounded) for the DUT to be idle. Returns at a falling edge.
   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", {15'd0, busy}, 16'd0);
   endtask

   // One full operation. It checks the done latency (8 edges after the
   // accepting edge) and the one-cycle pulse width. The operand inputs are
   // scrambled right after acceptance.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input exp_t e);
      int n;
      wait_idle();
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      start  = 1'b0;
      mcand  = 8'($urandom);
      mplier = 8'($urandom);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_latency", 16'(n), 16'd8);
      @(posedge clk);
      #1;
      check("done_width", {15'd0, done}, 16'd0);
   endtask

   vec_t       vecs[12];
   logic [7:0] corners[5];
   int         dc0;

   initial begin
      checks     = 0;
      failures   = 0;
      cyc        = 0;
      done_count = 0;
      spacing_on = 1'b0;
      have_prev  = 1'b0;
      last_exp   = '0;
      rst_n      = 1'b0;
      start      = 1'b0;
      mcand      = 8'h00;
      mplier     = 8'h00;

      vecs[0]  = '{a: 8'h18, b: 8'h20, res: 8'h30, ov: 1'b0};
      vecs[1]  = '{a: 8'hD8, b: 8'h18, res: 8'hC4, ov: 1'b0};
      vecs[2]  = '{a: 8'h40, b: 8'h40, res: 8'h7F, ov: 1'b1};
      vecs[3]  = '{a: 8'h80, b: 8'h80, res: 8'h7F, ov: 1'b1};
      vecs[4]  = '{a: 8'h80, b: 8'h10, res: 8'h80, ov: 1'b0};
      vecs[5]  = '{a: 8'h7F, b: 8'hE0, res: 8'h80, ov: 1'b1};
      vecs[6]  = '{a: 8'hFF, b: 8'h01, res: 8'hFF, ov: 1'b0};
      vecs[7]  = '{a: 8'h01, b: 8'h01, res: 8'h00, ov: 1'b0};
      vecs[8]  = '{a: 8'h00, b: 8'h7F, res: 8'h00, ov: 1'b0};
      vecs[9]  = '{a: 8'h7F, b: 8'h7F, res: 8'h7F, ov: 1'b1};
      vecs[10] = '{a: 8'h10, b: 8'h10, res: 8'h10, ov: 1'b0};
      vecs[11] = '{a: 8'hF0, b: 8'hF0, res: 8'h10, ov: 1'b0};

      corners[0] = 8'h00;
      corners[1] = 8'h7F;
      corners[2] = 8'h80;
      corners[3] = 8'hFF;
      corners[4] = 8'h10;

      // ---- Reset held while start pulses: nothing may start ------------------
      repeat (2) @(negedge clk);
      start  = 1'b1;
      mcand  = 8'h40;
      mplier = 8'h40;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_done", {15'd0, done}, 16'd0);
      check("rst_result", {8'h00, result}, 16'h0000);
      check("rst_overflow", {15'd0, overflow}, 16'd0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_idle", {15'd0, busy}, 16'd0);

      // ---- Directed vectors ---------------------------------------------------
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].a, vecs[i].b, '{res: vecs[i].res, ov: vecs[i].ov});
      end

      // ---- start held high, operands changing every cycle ---------------------
      // With start held, acceptance falls on every tenth edge from the first.
      wait_idle();
      dc0        = done_count;
      have_prev  = 1'b0;
      spacing_on = 1'b1;
      start      = 1'b1;
      for (int k = 0; k < 50; k++) begin
         mcand  = 8'($urandom);
         mplier = 8'($urandom);
         if (k % 10 == 0) begin
            sb_q.push_back(model(mcand, mplier));
         end
         @(negedge clk);
      end
      start      = 1'b0;
      spacing_on = 1'b0;
      check("held_start_dones", 16'(done_count - dc0), 16'd5);

      // ---- Reset in the middle of RUN -----------------------------------------
      wait_idle();
      start  = 1'b1;
      mcand  = 8'h40;
      mplier = 8'h20;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_done", {15'd0, done}, 16'd0);
      check("abort_result", {8'h00, result}, 16'h0000);
      check("abort_overflow", {15'd0, overflow}, 16'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_done", {15'd0, done}, 16'd0);
      run_op(8'hD8, 8'h18, '{res: 8'hC4, ov: 1'b0});

      // ---- Corner pairs and random sweep --------------------------------------
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            run_op(corners[i], corners[j], model(corners[i], corners[j]));
         end
      end
      for (int n = 0; n < 2000; n++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(ra, rb, model(ra, rb));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 16'(sb_q.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
